// File: rtl/apb_completer_regfile.sv
// APB4 completer with a small byte-strobed register bank, fixed wait states and PSLVERR.
// Register 0 is a read-only ID word; the other registers clear on reset.
module apb_completer_regfile #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          NumRegs    = 16,
  parameter int unsigned          WaitStates = 2,
  parameter logic [DataWidth-1:0] IdValue    = 32'hA9B00001
) (
  input  logic                     PCLK,
  input  logic                     reset,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [AddrWidth-1:0]     PADDR,
  input  logic [DataWidth-1:0]     PWDATA,
  input  logic [DataWidth/8-1:0]   PSTRB,
  output logic                     PREADY,
  output logic [DataWidth-1:0]     PRDATA,
  output logic                     PSLVERR
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int unsigned CntWidth  = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DataWidth-1:0]  regs_q [NumRegs];

  logic [AddrWidth-1:0]  idx_full;
  logic [IdxWidth-1:0]   idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  err;
  logic                  wr_en;
  logic                  rd_en;
  logic [DataWidth-1:0]  rd_word;

  // Address decode
  assign idx_full     = PADDR / AddrWidth'(StrbWidth);
  assign misaligned   = (PADDR % AddrWidth'(StrbWidth)) != '0;
  assign out_of_range = idx_full >= AddrWidth'(NumRegs);
  assign idx          = idx_full[IdxWidth-1:0];
  assign err          = misaligned | out_of_range | (PWRITE & (idx_full == '0));

  assign PREADY  = (state_q == StAccess) & PSEL & PENABLE & (cnt_q == '0);
  assign PSLVERR = PREADY & err;
  assign wr_en   = PREADY & PWRITE & ~err;
  assign rd_en   = PREADY & ~PWRITE & ~err;

  assign rd_word = (idx == '0) ? IdValue : regs_q[idx];
  assign PRDATA  = rd_en ? rd_word : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // PSEL & PENABLE without a setup phase is ignored here.
        if (PSEL && !PENABLE) begin
          state_d = StAccess;
          cnt_d   = CntWidth'(WaitStates);
        end
      end
      StAccess: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (!PENABLE) begin
          // A fresh setup phase restarts the wait count.
          cnt_d = CntWidth'(WaitStates);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntWidth'(1);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (PSTRB[b]) begin
          regs_q[idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile (WaitStates=2, NumRegs=16).
module tb_apb_completer_regfile;

  localparam logic [31:0] Id = 32'hA9B00001;

  logic        PCLK;
  logic        reset;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] rd;
  logic        se;
  int          lat;

  apb_completer_regfile #(
    .AddrWidth (32),
    .DataWidth (32),
    .NumRegs   (16),
    .WaitStates(2),
    .IdValue   (Id)
  ) dut (
    .PCLK   (PCLK),
    .reset  (reset),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PREADY (PREADY),
    .PRDATA (PRDATA),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer; returns at the falling edge of the completion cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic slverr, output int cycles);
    bit done;
    done   = 1'b0;
    rdata  = '0;
    slverr = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    cycles = 1;
    @(negedge PCLK);
    check_eq("pready_in_setup", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge PCLK);
      if (PREADY) begin
        done   = 1'b1;
        rdata  = PRDATA;
        slverr = PSLVERR;
      end else begin
        cycles++;
        @(posedge PCLK); #1;
      end
    end
    check_eq("pready_seen", 32'(done), 32'd1);
  endtask

  task automatic bus_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  initial begin
    reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (2) @(posedge PCLK);
    #1 reset = 1'b0;
    @(negedge PCLK);
    check_eq("rst_pready", 32'(PREADY), 32'd0);
    check_eq("rst_pslverr", 32'(PSLVERR), 32'd0);
    check_eq("rst_prdata", PRDATA, 32'd0);

    // ID register and wait-state latency
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, se, lat);
    check_eq("id_latency", 32'(lat), 32'd3);
    check_eq("id_rdata", rd, Id);
    check_eq("id_slverr", 32'(se), 32'd0);
    bus_idle();

    // Full and partial strobe writes
    apb_xfer(1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, rd, se, lat);
    check_eq("wr8_slverr", 32'(se), 32'd0);
    check_eq("wr8_latency", 32'(lat), 32'd3);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, se, lat);
    check_eq("rd8_full", rd, 32'hDEADBEEF);
    apb_xfer(1'b1, 32'h8, 32'h11223344, 4'b0101, rd, se, lat);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, se, lat);
    check_eq("rd8_strb0101", rd, 32'hDE22BE44);
    apb_xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, rd, se, lat);
    check_eq("wr8_nostrb_slverr", 32'(se), 32'd0);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, se, lat);
    check_eq("rd8_after_nostrb", rd, 32'hDE22BE44);
    bus_idle();

    // Error responses
    apb_xfer(1'b1, 32'h0, 32'h12345678, 4'hF, rd, se, lat);
    check_eq("wr0_slverr", 32'(se), 32'd1);
    check_eq("wr0_prdata", rd, 32'd0);
    apb_xfer(1'b1, 32'h42, 32'h12345678, 4'hF, rd, se, lat);
    check_eq("wr42_slverr", 32'(se), 32'd1);
    check_eq("wr42_prdata", rd, 32'd0);
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, se, lat);
    check_eq("rd40_slverr", 32'(se), 32'd1);
    check_eq("rd40_prdata", rd, 32'd0);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, se, lat);
    check_eq("id_after_err", rd, Id);
    check_eq("id_after_err_slverr", 32'(se), 32'd0);
    apb_xfer(1'b0, 32'h6, 32'h0, 4'h0, rd, se, lat);
    check_eq("rd6_misaligned_slverr", 32'(se), 32'd1);

    // Back-to-back read/write stream; writes to idx 16..19 are out of range
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp_rd;
      exp_rd = (i == 0) ? Id : ((i == 2) ? 32'hDE22BE44 : 32'd0);
      apb_xfer(1'b0, 32'(4 * i), 32'h0, 4'h0, rd, se, lat);
      check_eq($sformatf("b2b_rd%0d", i), rd, exp_rd);
      check_eq($sformatf("b2b_rd%0d_lat", i), 32'(lat), 32'd3);
      apb_xfer(1'b1, 32'(4 * (i + 10)), 32'(2 * i), 4'hF, rd, se, lat);
      check_eq($sformatf("b2b_wr%0d_slverr", i), 32'(se), (i >= 6) ? 32'd1 : 32'd0);
      check_eq($sformatf("b2b_wr%0d_lat", i), 32'(lat), 32'd3);
    end
    bus_idle();
    @(negedge PCLK);
    check_eq("b2b_no_extra_pready", 32'(PREADY), 32'd0);
    for (int i = 0; i < 6; i++) begin
      apb_xfer(1'b0, 32'(32'h28 + 4 * i), 32'h0, 4'h0, rd, se, lat);
      check_eq($sformatf("rdback_%0d", i), rd, 32'(2 * i));
    end
    bus_idle();

    // PSEL&PENABLE with no setup phase is ignored
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hCAFEF00D;
    PSTRB = 4'hF;
    repeat (3) begin
      @(negedge PCLK);
      check_eq("noset_pready", 32'(PREADY), 32'd0);
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;

    // Abort: drop PSEL during the 2nd wait cycle
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h55AA55AA;
    PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check_eq("abort_wait1_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(negedge PCLK);
    check_eq("abort_wait2_pready", 32'(PREADY), 32'd0);
    bus_idle();
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, se, lat);
    check_eq("abort_reg1", rd, 32'd0);
    check_eq("abort_recover_lat", 32'(lat), 32'd3);

    // Reset in the middle of a write
    apb_xfer(1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, rd, se, lat);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, se, lat);
    check_eq("pre_rst_reg1", rd, 32'hFFFFFFFF);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h12345678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    reset = 1'b1;
    @(negedge PCLK);
    check_eq("midrst_pready_before", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    reset = 1'b0;
    @(negedge PCLK);
    check_eq("midrst_pready", 32'(PREADY), 32'd0);
    check_eq("midrst_pslverr", 32'(PSLVERR), 32'd0);
    check_eq("midrst_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_eq("midrst_pready_later", 32'(PREADY), 32'd0);
    bus_idle();
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, se, lat);
    check_eq("midrst_reg1", rd, 32'd0);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, se, lat);
    check_eq("midrst_reg2", rd, 32'd0);
    bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
